// File: rtl/apb_i2cs_arbiter.sv
// apb_i2cs_arbiter
// Two-requester APB arbiter in front of the I2C peripheral completer port.
// Each granted request becomes exactly one SETUP + ACCESS pair downstream.
// Ties are broken round-robin (RR_ENABLE=1) or with m0 always winning (RR_ENABLE=0).
// The completion (pready, prdata) is returned only to the granted requester.
module apb_i2cs_arbiter #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int RR_ENABLE      = 1
) (
    input  logic                      apb_pclk_i,
    input  logic                      apb_presetn_i,

    input  logic [APB_ADDR_WIDTH-1:0] m0_paddr_i,
    input  logic                      m0_psel_i,
    input  logic                      m0_penable_i,
    input  logic                      m0_pwrite_i,
    input  logic [31:0]               m0_pwdata_i,
    output logic                      m0_pready_o,
    output logic [31:0]               m0_prdata_o,

    input  logic [APB_ADDR_WIDTH-1:0] m1_paddr_i,
    input  logic                      m1_psel_i,
    input  logic                      m1_penable_i,
    input  logic                      m1_pwrite_i,
    input  logic [31:0]               m1_pwdata_i,
    output logic                      m1_pready_o,
    output logic [31:0]               m1_prdata_o,

    output logic [APB_ADDR_WIDTH-1:0] s_paddr_o,
    output logic                      s_psel_o,
    output logic                      s_penable_o,
    output logic                      s_pwrite_o,
    output logic [31:0]               s_pwdata_o,
    input  logic                      s_pready_i,
    input  logic [31:0]               s_prdata_i,

    output logic [1:0]                gnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic                      write;
        logic [31:0]               wdata;
    } apb_req_t;

    state_t      state;
    logic        last_m1;      // 1 = m1 was granted last, so m0 wins the next tie
    logic        pick_m1;
    logic        in_access;
    logic [31:0] m0_prdata_q;
    logic [31:0] m1_prdata_q;
    apb_req_t    req0;
    apb_req_t    req1;
    apb_req_t    fwd;

    // The arbiter only looks at psel; penable from the requesters carries no extra
    // information because the arbiter generates its own downstream phases.
    logic unused_penable;
    assign unused_penable = m0_penable_i ^ m1_penable_i;

    assign req0      = '{addr: m0_paddr_i, write: m0_pwrite_i, wdata: m0_pwdata_i};
    assign req1      = '{addr: m1_paddr_i, write: m1_pwrite_i, wdata: m1_pwdata_i};
    assign in_access = (state == ACCESS);

    // Tie-break: round-robin against the last grant, or fixed m0 priority.
    always_comb begin
        pick_m1 = 1'b0;
        if (m0_psel_i && m1_psel_i)
            pick_m1 = (RR_ENABLE != 0) ? ~last_m1 : 1'b0;
        else
            pick_m1 = m1_psel_i;
    end

    // Arbitration FSM; downstream psel/penable and the grant are registered here.
    always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
        if (!apb_presetn_i) begin
            state       <= IDLE;
            gnt_o       <= 2'b00;
            s_psel_o    <= 1'b0;
            s_penable_o <= 1'b0;
            last_m1     <= 1'b1;
            m0_prdata_q <= '0;
            m1_prdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_psel_i || m1_psel_i) begin
                        gnt_o    <= pick_m1 ? 2'b10 : 2'b01;
                        s_psel_o <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    s_penable_o <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    // Wait states are unbounded; the peripheral decides when we finish.
                    if (s_pready_i) begin
                        if (gnt_o[0]) m0_prdata_q <= s_prdata_i;
                        if (gnt_o[1]) m1_prdata_q <= s_prdata_i;
                        last_m1     <= gnt_o[1];
                        gnt_o       <= 2'b00;
                        s_psel_o    <= 1'b0;
                        s_penable_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    gnt_o       <= 2'b00;
                    s_psel_o    <= 1'b0;
                    s_penable_o <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Forward the granted requester's address/control/data; zeros while idle.
    // The mux follows the grant, not psel, so a requester that drops psel early
    // still gets a well-formed downstream transfer.
    always_comb begin
        fwd = '0;
        if (gnt_o[0])
            fwd = req0;
        else if (gnt_o[1])
            fwd = req1;
    end

    assign s_paddr_o  = fwd.addr;
    assign s_pwrite_o = fwd.write;
    assign s_pwdata_o = fwd.wdata;

    // Completion is combinational so the requester samples prdata alongside pready;
    // outside the completing cycle the last captured word is held for debug.
    assign m0_pready_o = gnt_o[0] & in_access & s_pready_i;
    assign m1_pready_o = gnt_o[1] & in_access & s_pready_i;
    assign m0_prdata_o = m0_pready_o ? s_prdata_i : m0_prdata_q;
    assign m1_prdata_o = m1_pready_o ? s_prdata_i : m1_prdata_q;

endmodule

// File: tb/tb_apb_i2cs_arbiter.sv
// Bench for apb_i2cs_arbiter: a round-robin instance and a fixed-priority instance
// share one set of inputs. Directed table vectors, hand sequences for wait states,
// async reset and early psel drop, then random traffic against a reference model.
module tb_apb_i2cs_arbiter;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] m0_addr, m1_addr;
    logic          m0_sel, m0_en, m0_wr, m1_sel, m1_en, m1_wr;
    logic [31:0]   m0_wd, m1_wd;
    logic          s_rdy;
    logic [31:0]   s_rd;

    // index 0 = RR_ENABLE=1 instance, index 1 = RR_ENABLE=0 instance
    logic          o_rdy0 [2];
    logic          o_rdy1 [2];
    logic [31:0]   o_prd0 [2];
    logic [31:0]   o_prd1 [2];
    logic [AW-1:0] o_addr [2];
    logic          o_psel [2];
    logic          o_pen  [2];
    logic          o_wr   [2];
    logic [31:0]   o_wd   [2];
    logic [1:0]    o_gnt  [2];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    apb_i2cs_arbiter #(.APB_ADDR_WIDTH(AW), .RR_ENABLE(1)) u_rr (
        .apb_pclk_i(clk), .apb_presetn_i(rst_n),
        .m0_paddr_i(m0_addr), .m0_psel_i(m0_sel), .m0_penable_i(m0_en),
        .m0_pwrite_i(m0_wr), .m0_pwdata_i(m0_wd),
        .m0_pready_o(o_rdy0[0]), .m0_prdata_o(o_prd0[0]),
        .m1_paddr_i(m1_addr), .m1_psel_i(m1_sel), .m1_penable_i(m1_en),
        .m1_pwrite_i(m1_wr), .m1_pwdata_i(m1_wd),
        .m1_pready_o(o_rdy1[0]), .m1_prdata_o(o_prd1[0]),
        .s_paddr_o(o_addr[0]), .s_psel_o(o_psel[0]), .s_penable_o(o_pen[0]),
        .s_pwrite_o(o_wr[0]), .s_pwdata_o(o_wd[0]),
        .s_pready_i(s_rdy), .s_prdata_i(s_rd), .gnt_o(o_gnt[0])
    );

    apb_i2cs_arbiter #(.APB_ADDR_WIDTH(AW), .RR_ENABLE(0)) u_fp (
        .apb_pclk_i(clk), .apb_presetn_i(rst_n),
        .m0_paddr_i(m0_addr), .m0_psel_i(m0_sel), .m0_penable_i(m0_en),
        .m0_pwrite_i(m0_wr), .m0_pwdata_i(m0_wd),
        .m0_pready_o(o_rdy0[1]), .m0_prdata_o(o_prd0[1]),
        .m1_paddr_i(m1_addr), .m1_psel_i(m1_sel), .m1_penable_i(m1_en),
        .m1_pwrite_i(m1_wr), .m1_pwdata_i(m1_wd),
        .m1_pready_o(o_rdy1[1]), .m1_prdata_o(o_prd1[1]),
        .s_paddr_o(o_addr[1]), .s_psel_o(o_psel[1]), .s_penable_o(o_pen[1]),
        .s_pwrite_o(o_wr[1]), .s_pwdata_o(o_wd[1]),
        .s_pready_i(s_rdy), .s_prdata_i(s_rd), .gnt_o(o_gnt[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // {gnt, psel, penable, m0_pready, m1_pready}
    function automatic logic [63:0] ctrl_of(input int i);
        return {58'd0, o_gnt[i], o_psel[i], o_pen[i], o_rdy0[i], o_rdy1[i]};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        m0_sel = 1'b0; m0_en = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wd = '0;
        m1_sel = 1'b0; m1_en = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wd = '0;
        s_rdy = 1'b0; s_rd = '0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // ---------------- reference model (transfer-level) ----------------
    // phase: 0 = no transfer, 1 = first cycle after grant, 2 = waiting for completion
    int          m_phase [2];
    int          m_owner [2];
    int          m_last  [2];
    logic [31:0] m_hold  [2][2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_owner[i] = 0; m_last[i] = 1;
            m_hold[i][0] = '0; m_hold[i][1] = '0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (m_phase[i] == 0) begin
                if (m0_sel || m1_sel) begin
                    if (m0_sel && m1_sel) m_owner[i] = (i == 0) ? 1 - m_last[i] : 0;
                    else                  m_owner[i] = m1_sel ? 1 : 0;
                    m_phase[i] = 1;
                end
            end else if (m_phase[i] == 1) begin
                m_phase[i] = 2;
            end else if (s_rdy) begin
                m_hold[i][m_owner[i]] = s_rd;
                m_last[i]  = m_owner[i];
                m_phase[i] = 0;
            end
        end
    endtask

    task automatic model_check(input int cyc);
        for (int i = 0; i < 2; i++) begin
            logic          busy, acc, r0, r1, ew;
            logic [1:0]    eg;
            logic [AW-1:0] ea;
            logic [31:0]   ewd, ep0, ep1;
            busy = (m_phase[i] != 0);
            acc  = (m_phase[i] == 2);
            eg   = !busy ? 2'b00 : ((m_owner[i] == 1) ? 2'b10 : 2'b01);
            r0   = acc && s_rdy && (m_owner[i] == 0);
            r1   = acc && s_rdy && (m_owner[i] == 1);
            ea   = !busy ? '0   : ((m_owner[i] == 1) ? m1_addr : m0_addr);
            ew   = !busy ? 1'b0 : ((m_owner[i] == 1) ? m1_wr   : m0_wr);
            ewd  = !busy ? '0   : ((m_owner[i] == 1) ? m1_wd   : m0_wd);
            ep0  = r0 ? s_rd : m_hold[i][0];
            ep1  = r1 ? s_rd : m_hold[i][1];
            check($sformatf("rnd c%0d i%0d ctrl", cyc, i), ctrl_of(i),
                  {58'd0, eg, busy, acc, r0, r1});
            check($sformatf("rnd c%0d i%0d addr/wr/wdata", cyc, i),
                  {19'd0, o_addr[i], o_wr[i], o_wd[i]}, {19'd0, ea, ew, ewd});
            check($sformatf("rnd c%0d i%0d prdata0", cyc, i), 64'(o_prd0[i]), 64'(ep0));
            check($sformatf("rnd c%0d i%0d prdata1", cyc, i), 64'(o_prd1[i]), 64'(ep1));
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic          m0_sel, m1_sel, m0_wr, m1_wr;
        logic [AW-1:0] m0_addr, m1_addr;
        logic          s_rdy;
        logic [31:0]   s_rd;
        logic [5:0]    ctrl;     // {gnt, psel, penable, m0_pready, m1_pready}
        logic [AW-1:0] addr;
        logic          wr;
        logic [31:0]   wd;
        logic [31:0]   prd0, prd1;
    } vec_t;

    vec_t        vecs [11];
    logic [1:0]  seen_rr [$];
    logic [1:0]  seen_fp [$];
    logic [1:0]  got_g, exp_g;
    int          lat, pulses;

    initial begin
        // both request together (m0 first, m1 three cycles later), then an m0 read of 0x010
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 12'h020, 12'h024, 1'b1, 32'h11, 6'b00_0_0_0_0, 12'h000, 1'b0, 32'h00, 32'h00, 32'h00};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 12'h020, 12'h024, 1'b1, 32'h11, 6'b01_1_0_0_0, 12'h020, 1'b1, 32'h5A, 32'h00, 32'h00};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 12'h020, 12'h024, 1'b1, 32'h11, 6'b01_1_1_1_0, 12'h020, 1'b1, 32'h5A, 32'h11, 32'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 12'h020, 12'h024, 1'b1, 32'h11, 6'b00_0_0_0_0, 12'h000, 1'b0, 32'h00, 32'h11, 32'h00};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 12'h020, 12'h024, 1'b1, 32'h22, 6'b10_1_0_0_0, 12'h024, 1'b1, 32'h3C, 32'h11, 32'h00};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 12'h020, 12'h024, 1'b1, 32'h22, 6'b10_1_1_0_1, 12'h024, 1'b1, 32'h3C, 32'h11, 32'h22};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h020, 12'h024, 1'b1, 32'h22, 6'b00_0_0_0_0, 12'h000, 1'b0, 32'h00, 32'h11, 32'h22};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h010, 12'h000, 1'b1, 32'hA5, 6'b00_0_0_0_0, 12'h000, 1'b0, 32'h00, 32'h11, 32'h22};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h010, 12'h000, 1'b1, 32'hA5, 6'b01_1_0_0_0, 12'h010, 1'b0, 32'h5A, 32'h11, 32'h22};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h010, 12'h000, 1'b1, 32'hA5, 6'b01_1_1_1_0, 12'h010, 1'b0, 32'h5A, 32'hA5, 32'h22};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h010, 12'h000, 1'b1, 32'hA5, 6'b00_0_0_0_0, 12'h000, 1'b0, 32'h00, 32'hA5, 32'h22};

        // reset values, checked while reset is still asserted
        rst_n = 1'b0;
        m0_sel = 1'b0; m0_en = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wd = '0;
        m1_sel = 1'b0; m1_en = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wd = '0;
        s_rdy = 1'b0; s_rd = '0;
        #3;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset i%0d ctrl", i), ctrl_of(i), 64'd0);
            check($sformatf("reset i%0d addr", i), 64'(o_addr[i]), 64'd0);
            check($sformatf("reset i%0d prdata0", i), 64'(o_prd0[i]), 64'd0);
            check($sformatf("reset i%0d prdata1", i), 64'(o_prd1[i]), 64'd0);
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // table-driven vectors
        m0_wd = 32'h5A; m1_wd = 32'h3C;
        for (int r = 0; r < 11; r++) begin
            m0_sel = vecs[r].m0_sel; m0_en = vecs[r].m0_sel; m0_wr = vecs[r].m0_wr; m0_addr = vecs[r].m0_addr;
            m1_sel = vecs[r].m1_sel; m1_en = vecs[r].m1_sel; m1_wr = vecs[r].m1_wr; m1_addr = vecs[r].m1_addr;
            s_rdy = vecs[r].s_rdy; s_rd = vecs[r].s_rd;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("vec%0d i%0d ctrl", r, i), ctrl_of(i), 64'(vecs[r].ctrl));
                check($sformatf("vec%0d i%0d addr/wr/wdata", r, i),
                      {19'd0, o_addr[i], o_wr[i], o_wd[i]},
                      {19'd0, vecs[r].addr, vecs[r].wr, vecs[r].wd});
                check($sformatf("vec%0d i%0d prdata0", r, i), 64'(o_prd0[i]), 64'(vecs[r].prd0));
                check($sformatf("vec%0d i%0d prdata1", r, i), 64'(o_prd1[i]), 64'(vecs[r].prd1));
            end
            @(posedge clk); #1;
        end

        // fairness: both request continuously for six transfers
        do_reset();
        m0_sel = 1'b1; m0_en = 1'b1; m0_addr = 12'h100; m0_wd = 32'h1;
        m1_sel = 1'b1; m1_en = 1'b1; m1_addr = 12'h104; m1_wd = 32'h2;
        s_rdy = 1'b1; s_rd = 32'h55;
        seen_rr.delete(); seen_fp.delete();
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (o_psel[0] && !o_pen[0]) seen_rr.push_back(o_gnt[0]);
            if (o_psel[1] && !o_pen[1]) seen_fp.push_back(o_gnt[1]);
            @(posedge clk); #1;
        end
        check("rr grant count", 64'(seen_rr.size()), 64'd6);
        check("fp grant count", 64'(seen_fp.size()), 64'd6);
        for (int g = 0; g < 6; g++) begin
            exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
            got_g = (g < seen_rr.size()) ? seen_rr[g] : 2'b00;
            check($sformatf("rr grant %0d", g), 64'(got_g), 64'(exp_g));
            got_g = (g < seen_fp.size()) ? seen_fp[g] : 2'b00;
            check($sformatf("fp grant %0d", g), 64'(got_g), 64'd1);
        end

        // wait states: five ACCESS cycles with s_pready low, completion on the sixth
        m1_sel = 1'b0; m1_en = 1'b0;
        m0_sel = 1'b1; m0_en = 1'b1; m0_wr = 1'b1; m0_addr = 12'h0AB; m0_wd = 32'hCAFE_0004;
        s_rdy = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("wait%0d ctrl", k), ctrl_of(0), 64'b01_1_1_0_0);
            check($sformatf("wait%0d addr", k), 64'(o_addr[0]), 64'h0AB);
            @(posedge clk); #1;
        end
        s_rdy = 1'b1; s_rd = 32'h1234_5678;
        @(negedge clk);
        check("wait6 ctrl", ctrl_of(0), 64'b01_1_1_1_0);
        check("wait6 prdata0", 64'(o_prd0[0]), 64'h1234_5678);
        m0_sel = 1'b0; m0_en = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("wait done ctrl", ctrl_of(0), 64'd0);
        check("wait done prdata0 hold", 64'(o_prd0[0]), 64'h1234_5678);
        @(posedge clk); #1;

        // async reset in the middle of ACCESS
        m0_sel = 1'b1; m0_en = 1'b1; m0_addr = 12'h0EE; s_rdy = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-reset access ctrl", ctrl_of(0), 64'b01_1_1_0_0);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            check($sformatf("mid reset i%0d ctrl", i), ctrl_of(i), 64'd0);
        m0_sel = 1'b0; m0_en = 1'b0;
        m1_sel = 1'b1; m1_en = 1'b1; m1_wr = 1'b0; m1_addr = 12'h0F0;
        s_rdy = 1'b1; s_rd = 32'hD00D_0005;
        #1 rst_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (o_rdy1[0]) begin
                lat = k;
                m1_sel = 1'b0; m1_en = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("post-reset m1 latency", 64'(lat), 64'd3);
        check("post-reset prdata1", 64'(o_prd1[0]), 64'hD00D_0005);

        // m1 drops psel in SETUP: transfer still completes, then m0 is served
        m1_sel = 1'b1; m1_en = 1'b0; m1_addr = 12'h0C0; m1_wr = 1'b0;
        s_rdy = 1'b1; s_rd = 32'hBEEF_0006;
        @(posedge clk); #1;
        m1_sel = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) check("drop setup gnt", 64'(o_gnt[0]), 64'h2);
            if (o_rdy1[0]) pulses++;
            @(posedge clk); #1;
        end
        check("drop pready pulses", 64'(pulses), 64'd1);
        check("drop prdata1 hold", 64'(o_prd1[0]), 64'hBEEF_0006);
        check("drop back to idle", ctrl_of(0), 64'd0);
        m0_sel = 1'b1; m0_en = 1'b1; m0_addr = 12'h0D0;
        @(posedge clk); #1;
        @(negedge clk);
        check("after drop m0 setup", ctrl_of(0), 64'b01_1_0_0_0);
        check("after drop m0 addr", 64'(o_addr[0]), 64'h0D0);
        @(posedge clk); #1;
        @(negedge clk);
        check("after drop m0 access", ctrl_of(0), 64'b01_1_1_1_0);
        m0_sel = 1'b0; m0_en = 1'b0;
        @(posedge clk); #1;

        // random traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            m0_sel  = ($urandom_range(0, 2) != 0);
            m1_sel  = ($urandom_range(0, 2) != 0);
            m0_en   = m0_sel; m1_en = m1_sel;
            m0_wr   = $urandom_range(0, 1) != 0;
            m1_wr   = $urandom_range(0, 1) != 0;
            m0_addr = AW'($urandom);
            m1_addr = AW'($urandom);
            m0_wd   = $urandom;
            m1_wd   = $urandom;
            s_rdy   = ($urandom_range(0, 3) != 0);
            s_rd    = $urandom;
            @(negedge clk);
            model_check(c);
            @(posedge clk);
            model_step();
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, %0d/%0d passed so far", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/apb_i2cs_arbiter.md
Name: apb_i2cs_arbiter

Overview:
- Two-requester APB arbiter in front of the single APB completer port of the I2C peripheral (slave) block.
- Lets the CPU (port m0) and a second APB master (port m1, e.g. a uDMA/autonomous sequencer) share register/FIFO access to the I2C peripheral.
- Serialises whole APB transfers: one SETUP + ACCESS pair downstream per granted request, with round-robin or fixed priority.
- The response is returned only to the granted requester.

Parameters:
- APB_ADDR_WIDTH, 12, address width on all three APB ports.
- RR_ENABLE, 1: 1 = round-robin between m0/m1; 0 = fixed priority, m0 always wins.

Ports:
- apb_pclk_i  in  1  clock; all logic on rising edge.
- apb_presetn_i  in  1  reset, asynchronous, active-low.
- m0_paddr_i  in  APB_ADDR_WIDTH  requester 0 address.
- m0_psel_i  in  1  requester 0 select.
- m0_penable_i  in  1  requester 0 enable.
- m0_pwrite_i  in  1  requester 0 write.
- m0_pwdata_i  in  32  requester 0 write data.
- m0_pready_o  out  1  requester 0 ready.
- m0_prdata_o  out  32  requester 0 read data.
- m1_* (same six signals as m0)  requester 1.
- s_paddr_o  out  APB_ADDR_WIDTH  to I2C peripheral.
- s_psel_o  out  1  to I2C peripheral.
- s_penable_o  out  1  to I2C peripheral.
- s_pwrite_o  out  1  to I2C peripheral.
- s_pwdata_o  out  32  to I2C peripheral.
- s_pready_i  in  1  from I2C peripheral.
- s_prdata_i  in  32  from I2C peripheral.
- gnt_o  out  2  one-hot current grant; 00 when idle (status/debug).

Behaviour:
- Reset (apb_presetn_i low, async): state=IDLE; s_psel_o=0; s_penable_o=0; gnt_o=00; m0/m1_pready_o=0; m*_prdata_o=0; last-grant pointer=m1, so m0 wins the first tie.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: request = mX_psel_i high.
    - No request: stay in IDLE.
    - One request: grant it.
    - Both, RR_ENABLE=1: grant the port not granted last.
    - Both, RR_ENABLE=0: grant m0.
    - Grant registered into gnt_o; next state SETUP.
  - SETUP (1 cycle): s_psel_o=1, s_penable_o=0; next state ACCESS.
  - ACCESS: s_psel_o=1, s_penable_o=1.
    - While s_pready_i=0: hold, wait states unbounded.
    - When s_pready_i=1: granted mX_pready_o=1 for exactly that cycle; last-grant pointer updated; gnt_o cleared; next state IDLE.
- s_paddr_o/s_pwrite_o/s_pwdata_o: combinational mux from the granted port while gnt_o!=00; held at 0 when idle. Requesters hold these stable while psel is high (APB rule).
- mX_prdata_o: registered s_prdata_i captured on the completing cycle for the granted port; otherwise holds its last value.
  - mX_pready_o is combinational (gnt_o[X] & ACCESS & s_pready_i), so the requester samples prdata in the same cycle it sees pready.
  - Design choice: the data path is combinational pass-through, with s_prdata_i muxed to the granted port while pready is high. The registered copy is for debug hold only.
- The ungranted requester sees pready_o=0 throughout, which is legal APB wait-state extension. It is re-arbitrated in the IDLE cycle after completion.
- Minimum latency, request psel to pready: 3 cycles (IDLE, SETUP, ACCESS with s_pready_i=1). Back-to-back throughput: one transfer per 3 cycles.
- Fairness (RR_ENABLE=1): with both ports requesting continuously, grants strictly alternate m0, m1, m0, ...
- Requester drops psel after grant (protocol violation): the downstream transfer still completes, with address/data from the mux at that time, and the response is discarded. No hang.
- Reset asserted mid-transfer: immediate return to IDLE; all outputs go to reset values asynchronously.
- No address decoding; all addresses are forwarded unchanged. pslverr is not supported.

Test Plan:
1. m0 read only, addr 0x010, s_pready_i tied 1, s_prdata_i=0x0000_00A5 -> s_psel_o high cycles 1–2, s_penable_o high cycle 2; m0_pready_o=1 in cycle 2 with m0_prdata_o=0xA5; m1_pready_o stays 0; gnt_o=01 during cycles 1–2.
2. m0 write 0x5A to 0x020 and m1 write 0x3C to 0x024, psel asserted in the same cycle, RR_ENABLE=1 -> m0 served first, then m1. s_paddr_o sequence 0x020, 0x024; s_pwdata_o 0x5A, 0x3C; m1 waits 3 extra cycles.
3. Both requesters continuous for 6 transfers, RR_ENABLE=1 -> gnt_o sequence 01,10,01,10,01,10. With RR_ENABLE=0 -> all six to m0 while m0 keeps requesting.
4. s_pready_i held low for 5 ACCESS cycles -> s_psel_o/s_penable_o stay 1, address stable, m0_pready_o=0 until the 6th cycle, then one-cycle pulse.
5. apb_presetn_i pulsed low during ACCESS -> s_psel_o, s_penable_o, gnt_o go 0 without a clock edge. After release, a new m1 request completes normally in 3 cycles.
6. m1 drops psel in SETUP -> downstream transfer completes, m1_pready_o pulses once, the FSM returns to IDLE, and a subsequent m0 request is granted.
